// File: rtl/booth_encoder_r4_if.sv
// Bus bundle for one radix-4 Booth partial-product row.
// Handshake: valid-only, no backpressure. The producer asserts in_valid for
// exactly the cycles whose x/operand must be captured, and every such cycle is
// accepted. out_valid pulses for one cycle after each accepted input.
interface booth_encoder_r4_if #(
  parameter int XW = 8,
  parameter int PW = 16
);
  logic          in_valid;
  logic [XW-1:0] x;
  logic [2:0]    operand;
  logic [PW-1:0] partial_p;
  logic          out_valid;
  logic          neg;
  logic          two;
  logic          zero;

  // Producer side: drives the triplet and multiplicand, observes the row.
  modport master (
    output in_valid, x, operand,
    input  partial_p, out_valid, neg, two, zero
  );

  // Encoder side: consumes the triplet and multiplicand, drives the row.
  modport slave (
    input  in_valid, x, operand,
    output partial_p, out_valid, neg, two, zero
  );
endinterface

// File: rtl/booth_encoder_r4.sv
// Registered radix-4 Booth partial-product generator. One Booth triplet and a
// signed multiplicand produce a sign-extended partial product of 0, +-x or
// +-2x, with the decoded neg/two/zero flags registered alongside it.
module booth_encoder_r4 #(
  parameter int XW = 8,
  parameter int PW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  booth_encoder_r4_if.slave   bus
);

  logic [PW-1:0] x_ext;
  logic [PW-1:0] x_dbl;
  logic [PW-1:0] mag;
  logic [PW-1:0] pp_d;
  logic          neg_d;
  logic          two_d;
  logic          zero_d;

  // Decode the triplet into Booth control flags. 111 is a zero row, not a
  // negated one, so it must not set neg.
  always_comb begin
    neg_d  = 1'b0;
    two_d  = 1'b0;
    zero_d = 1'b0;
    case (bus.operand)
      3'b000:  zero_d = 1'b1;
      3'b011:  two_d  = 1'b1;
      3'b100:  begin neg_d = 1'b1; two_d = 1'b1; end
      3'b101:  neg_d  = 1'b1;
      3'b110:  neg_d  = 1'b1;
      3'b111:  zero_d = 1'b1;
      default: ;
    endcase
  end

  // Build the partial product at full PW width so -(-128) and -2*(-128)
  // are exact; zero rows bypass the negator so 111 yields a clean 0.
  always_comb begin
    x_ext = {{(PW-XW){bus.x[XW-1]}}, bus.x};
    x_dbl = x_ext << 1;
    mag   = two_d ? x_dbl : x_ext;
    if (zero_d) begin
      pp_d = '0;
    end else if (neg_d) begin
      pp_d = ~mag + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      pp_d = mag;
    end
  end

  // Capture the row on a valid input; otherwise hold it and drop out_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.partial_p <= '0;
      bus.out_valid <= 1'b0;
      bus.neg       <= 1'b0;
      bus.two       <= 1'b0;
      bus.zero      <= 1'b1;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.partial_p <= pp_d;
        bus.neg       <= neg_d;
        bus.two       <= two_d;
        bus.zero      <= zero_d;
      end
    end
  end

endmodule

// File: tb/tb_booth_encoder_r4.sv
// Directed bench for booth_encoder_r4: reset, operand sweeps, extreme
// multiplicands, hold behaviour and reset colliding with a valid input.
module tb_booth_encoder_r4;

  localparam int XW = 8;
  localparam int PW = 16;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_pass;
  int n_fail;

  // Hand-computed decode tables, indexed by operand value.
  logic [7:0]    neg_tab;
  logic [7:0]    two_tab;
  logic [7:0]    zero_tab;
  logic [PW-1:0] exp_a7 [8];

  booth_encoder_r4_if #(.XW(XW), .PW(PW)) bus ();

  booth_encoder_r4 #(.XW(XW), .PW(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs away from the active edge, then sample 1 unit after it.
  task automatic drive(input logic rst, input logic v, input logic [XW-1:0] xx,
                       input logic [2:0] op);
    @(negedge clk);
    rst_n        = rst;
    bus.in_valid = v;
    bus.x        = xx;
    bus.operand  = op;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [PW-1:0] obs,
                       input logic [PW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_row(input string tag, input logic [PW-1:0] pp,
                           input logic ov, input logic [2:0] op);
    check({tag, " partial_p"}, bus.partial_p, pp);
    check({tag, " out_valid"}, {15'd0, bus.out_valid}, {15'd0, ov});
    check({tag, " neg"},  {15'd0, bus.neg},  {15'd0, neg_tab[op]});
    check({tag, " two"},  {15'd0, bus.two},  {15'd0, two_tab[op]});
    check({tag, " zero"}, {15'd0, bus.zero}, {15'd0, zero_tab[op]});
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    neg_tab  = 8'b0111_0000;
    two_tab  = 8'b0001_1000;
    zero_tab = 8'b1000_0001;
    exp_a7   = '{16'h0000, 16'hFFA7, 16'hFFA7, 16'hFF4E,
                 16'h00B2, 16'h0059, 16'h0059, 16'h0000};
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.x        = '0;
    bus.operand  = '0;

    // Reset state
    drive(1'b0, 1'b0, 8'h00, 3'b000);
    drive(1'b0, 1'b0, 8'h00, 3'b000);
    check("rst partial_p", bus.partial_p, 16'h0000);
    check("rst out_valid", {15'd0, bus.out_valid}, 16'd0);
    check("rst neg",  {15'd0, bus.neg},  16'd0);
    check("rst two",  {15'd0, bus.two},  16'd0);
    check("rst zero", {15'd0, bus.zero}, 16'd1);

    // x = 0 sweep: every row is zero, flags follow the table
    for (int op = 0; op < 8; op++) begin
      drive(1'b1, 1'b1, 8'h00, op[2:0]);
      check_row($sformatf("x00 op%0d", op), 16'h0000, 1'b1, op[2:0]);
    end

    // x = -89 sweep, back-to-back
    for (int op = 0; op < 8; op++) begin
      drive(1'b1, 1'b1, 8'hA7, op[2:0]);
      check_row($sformatf("xA7 op%0d", op), exp_a7[op], 1'b1, op[2:0]);
    end

    // x = -128 extremes
    drive(1'b1, 1'b1, 8'h80, 3'b001); check_row("x80 op1", 16'hFF80, 1'b1, 3'b001);
    drive(1'b1, 1'b1, 8'h80, 3'b011); check_row("x80 op3", 16'hFF00, 1'b1, 3'b011);
    drive(1'b1, 1'b1, 8'h80, 3'b101); check_row("x80 op5", 16'h0080, 1'b1, 3'b101);
    drive(1'b1, 1'b1, 8'h80, 3'b100); check_row("x80 op4", 16'h0100, 1'b1, 3'b100);

    // x = +127
    drive(1'b1, 1'b1, 8'h7F, 3'b011); check_row("x7F op3", 16'h00FE, 1'b1, 3'b011);
    drive(1'b1, 1'b1, 8'h7F, 3'b100); check_row("x7F op4", 16'hFF02, 1'b1, 3'b100);
    drive(1'b1, 1'b1, 8'h7F, 3'b110); check_row("x7F op6", 16'hFF81, 1'b1, 3'b110);
    drive(1'b1, 1'b1, 8'h7F, 3'b111); check_row("x7F op7", 16'h0000, 1'b1, 3'b111);

    // Hold: capture FF4E then idle with random inputs
    drive(1'b1, 1'b1, 8'hA7, 3'b011); check_row("hold cap", 16'hFF4E, 1'b1, 3'b011);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'($urandom_range(255)), 3'($urandom_range(7)));
      check_row($sformatf("hold idle%0d", i), 16'hFF4E, 1'b0, 3'b011);
    end

    // Reset wins over a valid input on the same edge
    drive(1'b1, 1'b1, 8'h7F, 3'b100); check_row("pre rst", 16'hFF02, 1'b1, 3'b100);
    drive(1'b0, 1'b1, 8'h7F, 3'b011);
    check_row("rst+valid", 16'h0000, 1'b0, 3'b000);

    // Recovery after reset
    drive(1'b1, 1'b1, 8'h7F, 3'b011); check_row("post rst", 16'h00FE, 1'b1, 3'b011);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/booth_encoder_r4.md
Name: booth_encoder_r4

Overview:
Registered radix-4 Booth partial-product generator for a signed 8-bit multiplicand. Takes one 3-bit Booth multiplier triplet {y[2i+1], y[2i], y[2i-1]} and produces the corresponding signed 16-bit partial product (0, ±x, ±2x), sign-extended. It is the per-row building block of the calculator's signed multiplier array; the downstream adder tree shifts and sums the rows.

Parameters:
XW, 8, multiplicand width in bits (two's complement).
PW, 16, partial-product width in bits (2*XW); the result is sign-extended to this width.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  qualifies x/operand for capture this cycle.
x  input  XW  signed multiplicand.
operand  input  3  Booth triplet {y[2i+1], y[2i], y[2i-1]}.
partial_p  output  PW  registered signed partial product.
out_valid  output  1  partial_p updated from a valid input on the previous edge.
neg  output  1  registered Booth "negate" decode (triplet selects -x or -2x).
two  output  1  registered Booth "magnitude 2" decode (triplet selects ±2x).
zero  output  1  registered Booth "zero" decode (triplet 000 or 111).

Behaviour:
- Reset: on a rising clk edge with rst_n=0, partial_p=0, out_valid=0, neg=0, two=0, zero=1. Reset overrides in_valid on the same edge; a capture in flight is discarded.
- Decode table (operand -> product): 000 -> 0; 001 -> +x; 010 -> +x; 011 -> +2x; 100 -> -2x; 101 -> -x; 110 -> -x; 111 -> 0.
- Decode flags: neg=1 for 100,101,110 (0 for 111); two=1 for 011,100; zero=1 for 000,111.
- Arithmetic: sign-extend x to PW bits. Form 2x as the sign-extended value shifted left by 1. Negate with two's complement (invert + 1) at full PW width. No overflow is possible: |2x| <= 256 fits in 16-bit signed. x=-128 must yield -x=+128 and -2x=+256 exactly.
- Zero rows produce exactly 16'h0000. No negative-zero artefact is allowed for 111.
- Latency: one cycle. When in_valid=1 at edge N, partial_p/neg/two/zero reflect those inputs after edge N, and out_valid=1.
- When in_valid=0 at an edge, partial_p and the flags hold their previous values and out_valid=0.
- There is no backpressure; every valid input is accepted.
- Back-to-back valid inputs produce one output per cycle, in order.
- X/Z on operand while in_valid=0 must not disturb the outputs.

Test Plan:
- Reset then x=8'h00, operand sweep 000..111 with in_valid=1 -> partial_p=16'h0000 every cycle, out_valid=1 one cycle after each input. neg/two/zero follow the decode table.
- x=8'hA7 (-89), operand 000..111 back-to-back -> 0000, FFA7, FFA7, FF4E, 00B2, 0059, 0059, 0000 on consecutive cycles.
- x=8'h80 (-128) -> operand 001: FF80; 011: FF00; 101: 0080; 100: 0100.
- x=8'h7F (+127) -> operand 011: 00FE; 100: FF02; 110: FF81; 111: 0000 with zero=1, neg=0.
- Hold check: capture x=8'hA7, operand=011 (FF4E), then in_valid=0 with random x/operand for 3 cycles -> partial_p stays FF4E, out_valid=0.
- Assert rst_n=0 on the same edge as in_valid=1 (x=8'h7F, operand=011) -> partial_p=0000, out_valid=0, zero=1 after the edge.
